// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matrix-multiply control sequencer:
// controller state encoding, default sizing and the last-entry encoding.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ADD  = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int DEF_NUM_PRODUCTS   = 8;   // 2x2x2 partial products
    localparam int DEF_IDX_W          = 4;   // register-file specifier width
    localparam int DEF_COUNT_W        = 8;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    // Index of the final partial product; LOAD leaves after this entry.
    localparam int DEF_LAST_ENTRY = DEF_NUM_PRODUCTS - 1;

    function automatic int last_index(input int num_products);
        return num_products - 1;
    endfunction

endpackage

// File: rtl/matmul_entry_counter.sv
// Loadable up-counter with synchronous clear, enable and a terminal-count
// flag. Drives the product entry index and doubles as the WAIT watchdog.
module matmul_entry_counter
    import matmul_pkg::*;
#(
    parameter int             W        = DEF_IDX_W,
    parameter logic [W-1:0]   TERMINAL = W'(DEF_LAST_ENTRY)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count,
    output logic         terminal
);

    // Count register: clear has priority over load, load over increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == TERMINAL);

endmodule

// File: rtl/matmul_sequencer.sv
// Handshaked controller for the 2x2 matrix-multiply datapath: steps the
// entry index through all partial products with register-file writes,
// launches the accumulator, waits for completion and reports the result.
// Optional WAIT watchdog enabled by defining MATMUL_SEQ_TIMEOUT_EN.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int NUM_PRODUCTS = DEF_NUM_PRODUCTS,
    parameter int IDX_W        = DEF_IDX_W,
    parameter int COUNT_W      = DEF_COUNT_W
`ifdef MATMUL_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic               ready,
    output logic               busy,
    output logic [IDX_W-1:0]   entry_idx,
    output logic               load_matrix,
    output logic               add_start,
    input  logic               add_done,
    output logic               result_valid,
    output logic [COUNT_W-1:0] matrix_count,
    output logic               timeout_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(last_index(NUM_PRODUCTS));

    state_t state_reg;
    state_t state_next;
    logic   entry_last;
    logic   wd_expired;

    // Entry index only advances inside LOAD and is zeroed whenever the
    // controller is not going to be in LOAD next cycle.
    matmul_entry_counter #(
        .W        (IDX_W),
        .TERMINAL (LAST_IDX)
    ) u_entry (
        .clock      (clock),
        .reset      (reset),
        .clear      (state_next != LOAD),
        .enable     (state_reg == LOAD),
        .load       (1'b0),
        .load_value ('0),
        .count      (entry_idx),
        .terminal   (entry_last)
    );

`ifdef MATMUL_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_count;

    // Watchdog counts cycles spent in WAIT; terminal marks the last allowed one.
    matmul_entry_counter #(
        .W        (WD_W),
        .TERMINAL (WD_W'(TIMEOUT_CYCLES - 1))
    ) u_watchdog (
        .clock      (clock),
        .reset      (reset),
        .clear      (state_reg != WAIT),
        .enable     (1'b1),
        .load       (1'b0),
        .load_value ('0),
        .count      (wd_count),
        .terminal   (wd_expired)
    );

    logic timeout_err_reg;

    // Sticky timeout flag, cleared by the next accepted start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_err_reg <= 1'b0;
        end else if (start && ready) begin
            timeout_err_reg <= 1'b0;
        end else if (state_reg == WAIT && !abort && !add_done && wd_expired) begin
            timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Controller state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode; abort only acts while busy, start only while ready.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                if (abort)           state_next = IDLE;
                else if (entry_last) state_next = ADD;
            end
            ADD:  state_next = abort ? IDLE : WAIT;
            WAIT: begin
                if (abort)           state_next = IDLE;
                else if (add_done)   state_next = DONE;
                else if (wd_expired) state_next = IDLE;
            end
            DONE: state_next = start ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Completed-multiply counter; bumps on entry to DONE so DONE shows it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            matrix_count <= '0;
        end else if (state_next == DONE && state_reg != DONE) begin
            matrix_count <= matrix_count + 1'b1;
        end
    end

    assign ready        = (state_reg == IDLE) || (state_reg == DONE);
    assign busy         = (state_reg == LOAD) || (state_reg == ADD) || (state_reg == WAIT);
    assign load_matrix  = (state_reg == LOAD);
    assign add_start    = (state_reg == ADD);
    assign result_valid = (state_reg == DONE);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer. Expected behaviour is derived
// from the operation timeline (8 load cycles, one launch cycle, a wait of
// known length, one result cycle) and a running count of completed runs.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   abort;
    logic                   add_done;
    logic                   ready;
    logic                   busy;
    logic [DEF_IDX_W-1:0]   entry_idx;
    logic                   load_matrix;
    logic                   add_start;
    logic                   result_valid;
    logic [DEF_COUNT_W-1:0] matrix_count;
    logic                   timeout_err;

    int checks   = 0;
    int failures = 0;
    int exp_count = 0;
    bit exp_terr  = 1'b0;

    matmul_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .ready        (ready),
        .busy         (busy),
        .entry_idx    (entry_idx),
        .load_matrix  (load_matrix),
        .add_start    (add_start),
        .add_done     (add_done),
        .result_valid (result_valid),
        .matrix_count (matrix_count),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    // Observed flag vector: {ready, busy, load_matrix, add_start, result_valid, timeout_err}
    function automatic logic [5:0] flags();
        return {ready, busy, load_matrix, add_start, result_valid, timeout_err};
    endfunction

    // One full multiply starting from IDLE/DONE at a negedge. wait_cycles is
    // the number of WAIT cycles before add_done. hold keeps start high all
    // along; chain leaves start high in DONE for a back-to-back successor.
    task automatic run_multiply(input int wait_cycles, input bit hold, input bit chain, input bit abort_too);
        logic [5:0] exp;
        start = 1'b1;
        abort = abort_too;
        exp_terr = 1'b0;
        for (int k = 0; k < DEF_NUM_PRODUCTS; k++) begin
            @(negedge clock);
            abort = 1'b0;
            start = hold ? 1'b1 : ($urandom_range(0, 2) == 0);
            exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exp_terr};
            checks++;
            if (flags() !== exp || entry_idx !== DEF_IDX_W'(k)) begin
                failures++;
                $display("FAIL load_step k=%0d flags=%b idx=%0d required flags=%b idx=%0d", k, flags(), entry_idx, exp, k);
            end
        end
        @(negedge clock);
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, exp_terr};
        checks++;
        if (flags() !== exp || entry_idx !== '0) begin
            failures++;
            $display("FAIL add_launch flags=%b idx=%0d required flags=%b idx=0", flags(), entry_idx, exp);
        end
        for (int w = 0; w <= wait_cycles; w++) begin
            @(negedge clock);
            start = hold ? 1'b1 : ($urandom_range(0, 2) == 0);
            exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_terr};
            checks++;
            if (flags() !== exp || entry_idx !== '0) begin
                failures++;
                $display("FAIL wait_step w=%0d flags=%b idx=%0d required flags=%b idx=0", w, flags(), entry_idx, exp);
            end
            add_done = (w == wait_cycles);
        end
        @(negedge clock);
        add_done = 1'b0;
        exp_count = (exp_count + 1) % (1 << DEF_COUNT_W);
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_terr};
        checks++;
        if (flags() !== exp || matrix_count !== DEF_COUNT_W'(exp_count)) begin
            failures++;
            $display("FAIL done_cycle flags=%b count=%0d required flags=%b count=%0d", flags(), matrix_count, exp, exp_count);
        end
        start = chain;
        if (!chain) begin
            @(negedge clock);
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_terr};
            checks++;
            if (flags() !== exp || matrix_count !== DEF_COUNT_W'(exp_count) || entry_idx !== '0) begin
                failures++;
                $display("FAIL back_to_idle flags=%b count=%0d idx=%0d required flags=%b count=%0d idx=0", flags(), matrix_count, entry_idx, exp, exp_count);
            end
        end
        $display("multiply: wait=%0d hold=%0b chain=%0b count=%0d", wait_cycles, hold, chain, matrix_count);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; add_done = 1'b0;
        @(negedge clock);
        checks++;
        if (flags() !== 6'b100000 || entry_idx !== '0 || matrix_count !== '0) begin
            failures++;
            $display("FAIL reset_state flags=%b idx=%0d count=%0d required flags=100000 idx=0 count=0", flags(), entry_idx, matrix_count);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (flags() !== 6'b100000 || matrix_count !== '0) begin
            failures++;
            $display("FAIL after_release flags=%b count=%0d required flags=100000 count=0", flags(), matrix_count);
        end
        $display("reset: flags=%b", flags());
    endtask

    task automatic test_basic();
        run_multiply(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run_multiply(0, 1'b1, (i < 2), 1'b0);
        // abort alongside start in IDLE and in DONE is ignored: start wins
        run_multiply(1, 1'b0, 1'b1, 1'b1);
        run_multiply(2, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_ignored_inputs();
        for (int i = 0; i < 3; i++) begin
            add_done = 1'b1;
            @(negedge clock);
            add_done = 1'b0;
            checks++;
            if (flags() !== {5'b10000, exp_terr} || matrix_count !== DEF_COUNT_W'(exp_count)) begin
                failures++;
                $display("FAIL idle_add_done flags=%b count=%0d required flags=%b count=%0d", flags(), matrix_count, {5'b10000, exp_terr}, exp_count);
            end
        end
        $display("idle add_done pulses ignored: count=%0d", matrix_count);
    endtask

    task automatic test_abort(input int abort_idx, input bit in_wait, input int wait_n);
        int steps;
        steps = in_wait ? (DEF_NUM_PRODUCTS + 1 + wait_n + 1) : (abort_idx + 1);
        start = 1'b1;
        for (int s = 0; s < steps; s++) begin
            @(negedge clock);
            start = 1'b0;
            if (!in_wait) begin
                checks++;
                if (entry_idx !== DEF_IDX_W'(s) || load_matrix !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_load_step s=%0d idx=%0d load=%0b required idx=%0d load=1", s, entry_idx, load_matrix, s);
                end
            end
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checks++;
        if (flags() !== {5'b10000, exp_terr} || entry_idx !== '0 || matrix_count !== DEF_COUNT_W'(exp_count)) begin
            failures++;
            $display("FAIL abort_to_idle flags=%b idx=%0d count=%0d required flags=%b idx=0 count=%0d", flags(), entry_idx, matrix_count, {5'b10000, exp_terr}, exp_count);
        end
        $display("abort: in_wait=%0b idx=%0d count=%0d", in_wait, abort_idx, matrix_count);
        run_multiply(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++)
            run_multiply($urandom_range(0, 6), 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        start = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        exp_count = 0;
        exp_terr  = 1'b0;
        checks++;
        if (flags() !== 6'b100000 || entry_idx !== '0 || matrix_count !== '0) begin
            failures++;
            $display("FAIL async_reset flags=%b idx=%0d count=%0d required flags=100000 idx=0 count=0", flags(), entry_idx, matrix_count);
        end
        @(negedge clock);
        reset = 1'b0;
        $display("async reset mid-load: flags=%b idx=%0d", flags(), entry_idx);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < (1 << DEF_COUNT_W); i++)
            run_multiply(i % 3, 1'b0, (i % 2 == 0) && (i != (1 << DEF_COUNT_W) - 1), 1'b0);
        checks++;
        if (matrix_count !== '0) begin
            failures++;
            $display("FAIL count_wrap count=%0d required 0", matrix_count);
        end
    endtask

    task automatic test_timeout();
`ifdef MATMUL_SEQ_TIMEOUT_EN
        start = 1'b1;
        for (int s = 0; s < DEF_NUM_PRODUCTS + 1; s++) begin
            @(negedge clock);
            start = 1'b0;
        end
        for (int w = 0; w < DEF_TIMEOUT_CYCLES; w++) begin
            @(negedge clock);
            checks++;
            if (flags() !== 6'b010000) begin
                failures++;
                $display("FAIL timeout_wait w=%0d flags=%b required 010000", w, flags());
            end
        end
        @(negedge clock);
        exp_terr = 1'b1;
        checks++;
        if (flags() !== 6'b100001 || matrix_count !== DEF_COUNT_W'(exp_count)) begin
            failures++;
            $display("FAIL timeout_exit flags=%b count=%0d required flags=100001 count=%0d", flags(), matrix_count, exp_count);
        end
        @(negedge clock);
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky err=%0b required 1", timeout_err);
        end
        $display("timeout: err=%0b", timeout_err);
        run_multiply(2, 1'b0, 1'b0, 1'b0);
`else
        run_multiply(DEF_TIMEOUT_CYCLES + 4, 1'b0, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignored_inputs();
        test_abort(4, 1'b0, 0);
        test_abort(0, 1'b1, 3);
        test_random();
        test_async_reset();
        test_wrap();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound on simulation time.
    initial begin
        #1000000;
        $display("FAIL watchdog_timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
